mux4way16_merge: RTL and testbench

Four-to-one 16-bit merge stage: the collecting counterpart of the 4-way 16-bit demultiplexer. It accepts words from four independent valid/ready input channels, arbitrates among them, and forwards one word per cycle through a registered output channel. Each word carries a 2-bit tag naming its source channel, so a downstream demux can route it back out. It sits wherever four producers share one 16-bit datapath.

---
 rtl/mux4way16_merge.sv | 64 ++++++
 tb/tb_mux4way16_merge.sv | 117 +++++++++++
 2 files changed

// File: rtl/mux4way16_merge.sv
// mux4way16_merge: four-channel valid/ready merge onto one registered, source-tagged output.
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in0..in3   channel data, in_valid[i] marks channel i holding a word
//   in_ready   one-hot accept strobe for the granted channel (zero when nothing loads)
//   out        registered output word, out_sel its source channel, out_valid marks it live
//   out_ready  downstream accepts the word this cycle
//   MUX4WAY16_MERGE_RR_EN selects round-robin arbitration; otherwise fixed priority (0 highest).
module mux4way16_merge #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       sel_q, sel_d, last_q, last_d, g;
    logic             valid_q, valid_d, load;
`ifdef MUX4WAY16_MERGE_RR_EN
    // Scan offsets from far to near so the channel just after last_q wins;
    // offset 4 wraps back to last_q itself as the lowest-priority candidate.
    always_comb begin
        g = last_q;
        for (int k = 4; k >= 1; k--)
            if (in_valid[last_q + 2'(k)]) g = last_q + 2'(k);
    end
`else
    always_comb g = in_valid[0] ? 2'd0 : in_valid[1] ? 2'd1 : in_valid[2] ? 2'd2 : 2'd3;
`endif
    // Nothing is accepted during reset so an offered word is never silently lost.
    assign load     = (|in_valid) && (!valid_q || out_ready) && !reset;
    assign in_ready = load ? 4'(1) << g : 4'd0;
    always_comb begin
        out_d   = load ? (g == 2'd0 ? in0 : g == 2'd1 ? in1 : g == 2'd2 ? in2 : in3) : out_q;
        sel_d   = load ? g : sel_q;
        last_d  = load ? g : last_q;
        valid_d = load | (valid_q & ~out_ready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end
    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_mux4way16_merge.sv
// tb_mux4way16_merge: table-driven and hand-sequenced scoreboard bench for mux4way16_merge.
module tb_mux4way16_merge;
`ifdef MUX4WAY16_MERGE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in0, in1, in2, in3;
    logic [3:0]  in_valid, in_ready;
    logic [15:0] out;
    logic [1:0]  out_sel;
    logic        out_valid, out_ready;
    int          tests = 0, fails = 0;
    logic [17:0] sb[$];
    logic [17:0] stale;

    typedef struct {
        logic [3:0] iv;
        logic       ord;
        logic [3:0] er;
    } vec_t;
    vec_t tv[24];

    mux4way16_merge #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [1:0] idx(input logic [3:0] oh);
        return oh[1] ? 2'd1 : oh[2] ? 2'd2 : oh[3] ? 2'd3 : 2'd0;
    endfunction

    task automatic cyc(input logic [3:0] iv, input logic ord, input logic rst, input logic [3:0] er);
        logic [1:0] s;
        logic [15:0] d;
        in_valid  = iv;
        out_ready = ord;
        reset     = rst;
        #1;
        chk("in_ready", 32'(in_ready), 32'(er));
        if (rst) begin
            sb.delete();
            stale = '0;
        end else begin
            if (out_valid && ord && sb.size() != 0) stale = sb.pop_front();
            if (er != 4'd0) begin
                s = idx(er);
                d = s == 2'd0 ? in0 : s == 2'd1 ? in1 : s == 2'd2 ? in2 : in3;
                sb.push_back({s, d});
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) chk("out_word", {14'd0, out_sel, out}, {14'd0, sb[0]});
        else chk("out_stale", {14'd0, out_sel, out}, {14'd0, stale});
    endtask

    initial begin
        tv[0]  = '{4'b1111, 1'b1, 4'b0001};
        tv[1]  = '{4'b1111, 1'b1, RR ? 4'b0010 : 4'b0001};
        tv[2]  = '{4'b1111, 1'b1, RR ? 4'b0100 : 4'b0001};
        tv[3]  = '{4'b1111, 1'b1, RR ? 4'b1000 : 4'b0001};
        tv[4]  = '{4'b1111, 1'b1, 4'b0001};
        tv[5]  = '{4'b1111, 1'b1, RR ? 4'b0010 : 4'b0001};
        tv[6]  = '{4'b1111, 1'b1, RR ? 4'b0100 : 4'b0001};
        tv[7]  = '{4'b1111, 1'b1, RR ? 4'b1000 : 4'b0001};
        tv[8]  = '{4'b0100, 1'b1, 4'b0100};
        tv[9]  = '{4'b0000, 1'b1, 4'b0000};
        tv[10] = '{4'b0000, 1'b1, 4'b0000};
        tv[11] = '{4'b0011, 1'b1, 4'b0001};
        tv[12] = '{4'b0011, 1'b0, 4'b0000};
        tv[13] = '{4'b0011, 1'b0, 4'b0000};
        tv[14] = '{4'b0011, 1'b0, 4'b0000};
        tv[15] = '{4'b0011, 1'b1, RR ? 4'b0010 : 4'b0001};
        tv[16] = '{4'b0011, 1'b1, 4'b0001};
        tv[17] = '{4'b1000, 1'b0, 4'b0000};
        tv[18] = '{4'b1000, 1'b1, 4'b1000};
        tv[19] = '{4'b0000, 1'b1, 4'b0000};
        tv[20] = '{4'b0000, 1'b0, 4'b0000};
        tv[21] = '{4'b0010, 1'b0, 4'b0010};
        tv[22] = '{4'b0000, 1'b0, 4'b0000};
        tv[23] = '{4'b0000, 1'b1, 4'b0000};
        stale = '0;
        in0 = 16'h0000; in1 = 16'h1000; in2 = 16'h2000; in3 = 16'h3000;
        cyc(4'b1111, 1'b1, 1'b1, 4'b0000);
        cyc(4'b1111, 1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 24; i++) begin
            in0 = {4'h0, 12'(i)}; in1 = {4'h1, 12'(i)}; in2 = {4'h2, 12'(i)}; in3 = {4'h3, 12'(i)};
            cyc(tv[i].iv, tv[i].ord, 1'b0, tv[i].er);
        end
        in2 = 16'hBEEF;
        cyc(4'b0100, 1'b1, 1'b0, 4'b0100);
        cyc(4'b0000, 1'b1, 1'b0, 4'b0000);
        in0 = 16'hA000; in1 = 16'hA111; in2 = 16'hA222; in3 = 16'hA333;
        cyc(4'b0010, 1'b0, 1'b0, 4'b0010);
        cyc(4'b0010, 1'b0, 1'b0, 4'b0000);
        cyc(4'b1111, 1'b0, 1'b1, 4'b0000);
        cyc(4'b1111, 1'b1, 1'b0, 4'b0001);
        cyc(4'b0000, 1'b1, 1'b0, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
